// File: rtl/pifo_req_client.sv
// pifo_req_client: requester-side front end for the multi-lane SRAM PIFO tree.
// Routes one push/pop per cycle to lane (tree_id % LEVEL), gathers level-0 pop
// results into per-lane return FIFOs and drains them round-robin through a
// registered response stage. Pop credits bound the results that can be held.
module pifo_req_client #(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int LEVEL     = 4,
    parameter int TREE_NUM  = 4,
    parameter int RSP_DEPTH = 8,
    localparam int DW  = PTW + MTW,
    localparam int TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
    localparam int CW  = $clog2(RSP_DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_op,
    input  logic [TNB-1:0]            i_req_tree_id,
    input  logic [DW-1:0]             i_req_data,
    output logic [LEVEL-1:0]          o_push,
    output logic [LEVEL-1:0]          o_pop,
    output logic [LEVEL-1:0][TNB-1:0] o_tree_id,
    output logic [LEVEL-1:0][DW-1:0]  o_push_data,
    input  logic [LEVEL-1:0]          i_task_fifo_full,
    input  logic [LEVEL-1:0]          i_is_level0_pop,
    input  logic [LEVEL-1:0][TNB-1:0] i_pop_tree_id,
    input  logic [LEVEL-1:0][DW-1:0]  i_pop_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [TNB-1:0]            o_rsp_tree_id,
    output logic [DW-1:0]             o_rsp_data,
    output logic                      o_rsp_empty,
    output logic [CW-1:0]             o_credits_used,
    output logic                      o_err_unexpected,
    input  logic                      i_err_clr
);

    localparam int LB = (LEVEL > 1) ? $clog2(LEVEL) : 1;
    localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int EW = TNB + DW;

    logic [LB-1:0]  req_lane;
    logic           accept;
    logic           pop_accept;
    logic           consume;
    logic           load;

    logic [EW-1:0]  mem [LEVEL][RSP_DEPTH];
    logic [AW:0]    wr_ptr [LEVEL];
    logic [AW:0]    rd_ptr [LEVEL];
    logic [LEVEL-1:0] fifo_full;
    logic [LEVEL-1:0] fifo_empty;
    logic [LEVEL-1:0] wr_en;
    logic [LEVEL-1:0] rd_en;
    logic [LEVEL-1:0] avail;
    logic [EW-1:0]  head [LEVEL];

    logic [LB-1:0]  rr_ptr;
    logic [LB-1:0]  idx;
    logic [LB-1:0]  grant_lane;
    logic           grant_valid;

    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  outstanding_next;
    logic [CW-1:0]  credits_next;
    logic           err_set;
    int             out_tmp;
    int             unexp;
    int             credit_tmp;

    // Request routing and acceptance; a lane that issued last cycle is held off
    // because its task-FIFO full flag has not caught up yet.
    always_comb begin
        req_lane    = LB'(32'(i_req_tree_id) % LEVEL);
        o_req_ready = i_arst_n
                      && !i_task_fifo_full[req_lane]
                      && !o_push[req_lane] && !o_pop[req_lane]
                      && (i_req_op || (o_credits_used < CW'(RSP_DEPTH)));
        accept      = i_req_valid && o_req_ready;
        pop_accept  = accept && !i_req_op;
    end

    // Issue register: one-cycle strobe on the target lane, all other lanes zero.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_push      <= '0;
            o_pop       <= '0;
            o_tree_id   <= '0;
            o_push_data <= '0;
        end else begin
            o_push      <= '0;
            o_pop       <= '0;
            o_tree_id   <= '0;
            o_push_data <= '0;
            if (accept) begin
                o_push[req_lane]      <= i_req_op;
                o_pop[req_lane]       <= !i_req_op;
                o_tree_id[req_lane]   <= i_req_tree_id;
                o_push_data[req_lane] <= i_req_op ? i_req_data : '0;
            end
        end
    end

    // Return FIFO status; an empty FIFO forwards its incoming result directly.
    always_comb begin
        for (int k = 0; k < LEVEL; k++) begin
            fifo_empty[k] = (wr_ptr[k] == rd_ptr[k]);
            fifo_full[k]  = ((wr_ptr[k] - rd_ptr[k]) == (AW+1)'(RSP_DEPTH));
            wr_en[k]      = i_is_level0_pop[k] && !fifo_full[k];
            avail[k]      = !fifo_empty[k] || wr_en[k];
            head[k]       = fifo_empty[k] ? {i_pop_tree_id[k], i_pop_data[k]}
                                          : mem[k][rd_ptr[k][AW-1:0]];
        end
    end

    // Round-robin pick of the first lane with a result, starting at rr_ptr.
    always_comb begin
        idx         = '0;
        grant_lane  = '0;
        grant_valid = 1'b0;
        load        = !o_rsp_valid || i_rsp_ready;
        consume     = o_rsp_valid && i_rsp_ready;
        for (int i = 0; i < LEVEL; i++) begin
            idx = rr_ptr + LB'(i);
            if (!grant_valid && avail[idx]) begin
                grant_valid = 1'b1;
                grant_lane  = idx;
            end
        end
        for (int k = 0; k < LEVEL; k++) begin
            rd_en[k] = load && grant_valid && (grant_lane == LB'(k));
        end
    end

    // Return FIFO storage.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < LEVEL; k++) begin
            if (wr_en[k]) begin
                mem[k][wr_ptr[k][AW-1:0]] <= {i_pop_tree_id[k], i_pop_data[k]};
            end
        end
    end

    // Return FIFO pointers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int k = 0; k < LEVEL; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LEVEL; k++) begin
                if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (rd_en[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
            end
        end
    end

    // Registered response stage, refilled whenever empty or being consumed.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_rsp_valid   <= 1'b0;
            o_rsp_tree_id <= '0;
            o_rsp_data    <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            o_rsp_valid <= grant_valid;
            if (grant_valid) begin
                o_rsp_tree_id <= head[grant_lane][EW-1:DW];
                o_rsp_data    <= head[grant_lane][DW-1:0];
                rr_ptr        <= grant_lane + 1'b1;
            end else begin
                o_rsp_tree_id <= '0;
                o_rsp_data    <= '0;
            end
        end
    end

    assign o_rsp_empty = o_rsp_valid && (&o_rsp_data);

    // Credit bookkeeping: results with no outstanding pop are flagged and still
    // occupy a held credit until they are drained.
    always_comb begin
        out_tmp    = int'(outstanding);
        unexp      = 0;
        err_set    = 1'b0;
        for (int k = 0; k < LEVEL; k++) begin
            if (i_is_level0_pop[k]) begin
                if (out_tmp > 0) begin
                    out_tmp = out_tmp - 1;
                end else begin
                    unexp   = unexp + 1;
                    err_set = 1'b1;
                end
                if (fifo_full[k]) err_set = 1'b1;
            end
        end
        out_tmp    = out_tmp + int'(pop_accept);
        credit_tmp = int'(o_credits_used) + int'(pop_accept) + unexp - int'(consume);
        if (credit_tmp > RSP_DEPTH) credit_tmp = RSP_DEPTH;
        if (credit_tmp < 0) credit_tmp = 0;
        if (out_tmp > RSP_DEPTH) out_tmp = RSP_DEPTH;
        outstanding_next = CW'(out_tmp);
        credits_next     = CW'(credit_tmp);
    end

    // Credit counters and sticky error flag (set beats clear).
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            outstanding      <= '0;
            o_credits_used   <= '0;
            o_err_unexpected <= 1'b0;
        end else begin
            outstanding    <= outstanding_next;
            o_credits_used <= credits_next;
            if (err_set)        o_err_unexpected <= 1'b1;
            else if (i_err_clr) o_err_unexpected <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pifo_req_client.sv
// tb_pifo_req_client: directed self-checking bench for pifo_req_client.
module tb_pifo_req_client;

    logic             clk;
    logic             arst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [1:0]       req_tree_id;
    logic [15:0]      req_data;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [3:0][1:0]  tree_id;
    logic [3:0][15:0] push_data;
    logic [3:0]       task_fifo_full;
    logic [3:0]       is_level0_pop;
    logic [3:0][1:0]  pop_tree_id;
    logic [3:0][15:0] pop_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_tree_id;
    logic [15:0]      rsp_data;
    logic             rsp_empty;
    logic [3:0]       credits_used;
    logic             err_unexpected;
    logic             err_clr;

    int checks;
    int failures;
    logic [15:0] exp_seq [0:7];

    pifo_req_client dut (
        .i_clk            (clk),
        .i_arst_n         (arst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_op         (req_op),
        .i_req_tree_id    (req_tree_id),
        .i_req_data       (req_data),
        .o_push           (push),
        .o_pop            (pop),
        .o_tree_id        (tree_id),
        .o_push_data      (push_data),
        .i_task_fifo_full (task_fifo_full),
        .i_is_level0_pop  (is_level0_pop),
        .i_pop_tree_id    (pop_tree_id),
        .i_pop_data       (pop_data),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_tree_id    (rsp_tree_id),
        .o_rsp_data       (rsp_data),
        .o_rsp_empty      (rsp_empty),
        .o_credits_used   (credits_used),
        .o_err_unexpected (err_unexpected),
        .i_err_clr        (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic op, input logic [1:0] tid,
                                  input logic [15:0] data);
        req_valid   = valid;
        req_op      = op;
        req_tree_id = tid;
        req_data    = data;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        arst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 2'd0, 16'h0);
        task_fifo_full = '0;
        is_level0_pop = '0;
        pop_tree_id = '0;
        pop_data = '0;
        rsp_ready = 1'b0;
        err_clr = 1'b0;
        exp_seq[0] = 16'h1002; exp_seq[1] = 16'h1003; exp_seq[2] = 16'h1000; exp_seq[3] = 16'h1001;
        exp_seq[4] = 16'h2002; exp_seq[5] = 16'h2003; exp_seq[6] = 16'h2000; exp_seq[7] = 16'h2001;

        // reset state
        #3;
        check_output("rst_push", 32'(push), 32'h0);
        check_output("rst_pop", 32'(pop), 32'h0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("rst_credits", 32'(credits_used), 32'h0);
        check_output("rst_err", 32'(err_unexpected), 32'h0);
        check_output("rst_ready", 32'(req_ready), 32'h0);
        #19 arst_n = 1'b1;
        cyc(); cyc(); cyc();

        // push tree 2 data 0x1234
        apply_stimulus(1'b1, 1'b1, 2'd2, 16'h1234);
        settle();
        check_output("push_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 1'b0;
        settle();
        check_output("push_strobe", 32'(push), 32'h4);
        check_output("push_pop_zero", 32'(pop), 32'h0);
        check_output("push_tid2", 32'(tree_id[2]), 32'h2);
        check_output("push_data2", 32'(push_data[2]), 32'h1234);
        check_output("push_lane_busy", 32'(req_ready), 32'h0);
        cyc();
        check_output("push_strobe_off", 32'(push), 32'h0);
        check_output("push_data_off", 32'(push_data), 32'h0);
        check_output("push_no_rsp", 32'(rsp_valid), 32'h0);

        // round robin: pops to lanes 0 and 3, both results in one cycle
        apply_stimulus(1'b1, 1'b0, 2'd0, 16'h0);
        cyc();
        apply_stimulus(1'b1, 1'b0, 2'd3, 16'h0);
        cyc();
        req_valid = 1'b0;
        check_output("rr_pop3", 32'(pop), 32'h8);
        check_output("rr_credits2", 32'(credits_used), 32'h2);
        is_level0_pop = 4'b1001;
        pop_tree_id[0] = 2'd0; pop_data[0] = 16'h0A0A;
        pop_tree_id[3] = 2'd3; pop_data[3] = 16'h3B3B;
        rsp_ready = 1'b1;
        cyc();
        is_level0_pop = '0;
        check_output("rr_first_valid", 32'(rsp_valid), 32'h1);
        check_output("rr_first_tid", 32'(rsp_tree_id), 32'h0);
        check_output("rr_first_data", 32'(rsp_data), 32'h0A0A);
        cyc();
        check_output("rr_second_tid", 32'(rsp_tree_id), 32'h3);
        check_output("rr_second_data", 32'(rsp_data), 32'h3B3B);
        check_output("rr_credits1", 32'(credits_used), 32'h1);
        cyc();
        rsp_ready = 1'b0;
        check_output("rr_drained", 32'(rsp_valid), 32'h0);
        check_output("rr_credits0", 32'(credits_used), 32'h0);
        check_output("rr_no_err", 32'(err_unexpected), 32'h0);

        // single pop on tree 1 with response handshake
        apply_stimulus(1'b1, 1'b0, 2'd1, 16'hFFFF);
        settle();
        check_output("pop1_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 1'b0;
        check_output("pop1_strobe", 32'(pop), 32'h2);
        check_output("pop1_data_zero", 32'(push_data[1]), 32'h0);
        check_output("pop1_credits", 32'(credits_used), 32'h1);
        cyc(); cyc();
        is_level0_pop[1] = 1'b1; pop_tree_id[1] = 2'd1; pop_data[1] = 16'h00AA;
        cyc();
        is_level0_pop = '0;
        check_output("pop1_rsp_valid", 32'(rsp_valid), 32'h1);
        check_output("pop1_rsp_tid", 32'(rsp_tree_id), 32'h1);
        check_output("pop1_rsp_data", 32'(rsp_data), 32'h00AA);
        check_output("pop1_rsp_notempty", 32'(rsp_empty), 32'h0);
        check_output("pop1_credits_held", 32'(credits_used), 32'h1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check_output("pop1_credits_free", 32'(credits_used), 32'h0);
        check_output("pop1_rsp_gone", 32'(rsp_valid), 32'h0);

        // credit exhaustion: eight pops, results held, ninth pop blocked
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 2'(i % 4), 16'h0);
            settle();
            check_output("cred_pop_ready", 32'(req_ready), 32'h1);
            cyc();
        end
        req_valid = 1'b0;
        check_output("cred_full8", 32'(credits_used), 32'h8);
        is_level0_pop = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            pop_tree_id[k] = 2'(k);
            pop_data[k] = 16'h1000 + 16'(k);
        end
        cyc();
        for (int k = 0; k < 4; k++) pop_data[k] = 16'h2000 + 16'(k);
        cyc();
        is_level0_pop = '0;
        check_output("cred_hold_valid", 32'(rsp_valid), 32'h1);
        check_output("cred_hold_data", 32'(rsp_data), 32'h1002);
        check_output("cred_still8", 32'(credits_used), 32'h8);
        check_output("cred_no_err", 32'(err_unexpected), 32'h0);
        apply_stimulus(1'b1, 1'b0, 2'd0, 16'h0);
        settle();
        check_output("cred_pop9_blocked", 32'(req_ready), 32'h0);
        apply_stimulus(1'b1, 1'b1, 2'd1, 16'hBEEF);
        settle();
        check_output("cred_push_ok", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 1'b0;
        check_output("cred_push_strobe", 32'(push), 32'h2);
        check_output("cred_push_data", 32'(push_data[1]), 32'hBEEF);
        rsp_ready = 1'b1;
        settle();
        for (int i = 0; i < 8; i++) begin
            check_output("cred_drain_data", 32'(rsp_data), 32'(exp_seq[i]));
            check_output("cred_drain_tid", 32'(rsp_tree_id), 32'(exp_seq[i][1:0]));
            check_output("cred_drain_cnt", 32'(credits_used), 32'(8 - i));
            cyc();
        end
        check_output("cred_drain_done", 32'(rsp_valid), 32'h0);
        check_output("cred_drain_zero", 32'(credits_used), 32'h0);
        rsp_ready = 1'b0;

        // task FIFO full stall, then release
        task_fifo_full[1] = 1'b1;
        apply_stimulus(1'b1, 1'b1, 2'd1, 16'h0055);
        settle();
        check_output("full_stall", 32'(req_ready), 32'h0);
        cyc();
        check_output("full_no_push", 32'(push), 32'h0);
        task_fifo_full[1] = 1'b0;
        settle();
        check_output("full_release", 32'(req_ready), 32'h1);
        cyc();
        check_output("full_push_strobe", 32'(push), 32'h2);

        // back-to-back requests to lane 0
        apply_stimulus(1'b1, 1'b1, 2'd0, 16'h0001);
        settle();
        check_output("b2b_first_ready", 32'(req_ready), 32'h1);
        cyc();
        req_data = 16'h0002;
        settle();
        check_output("b2b_second_blocked", 32'(req_ready), 32'h0);
        check_output("b2b_first_data", 32'(push_data[0]), 32'h0001);
        cyc();
        check_output("b2b_gap", 32'(push), 32'h0);
        settle();
        check_output("b2b_second_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 1'b0;
        check_output("b2b_second_strobe", 32'(push), 32'h1);
        check_output("b2b_second_data", 32'(push_data[0]), 32'h0002);

        // unexpected result on lane 2, then clear
        is_level0_pop[2] = 1'b1; pop_tree_id[2] = 2'd2; pop_data[2] = 16'h5555;
        rsp_ready = 1'b1;
        cyc();
        is_level0_pop = '0;
        check_output("unexp_err", 32'(err_unexpected), 32'h1);
        check_output("unexp_credit", 32'(credits_used), 32'h1);
        check_output("unexp_rsp", 32'(rsp_data), 32'h5555);
        cyc();
        check_output("unexp_credit_back", 32'(credits_used), 32'h0);
        check_output("unexp_sticky", 32'(err_unexpected), 32'h1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check_output("unexp_cleared", 32'(err_unexpected), 32'h0);

        // set beats clear in the same cycle
        err_clr = 1'b1;
        is_level0_pop[3] = 1'b1; pop_tree_id[3] = 2'd3; pop_data[3] = 16'h7777;
        cyc();
        is_level0_pop = '0;
        check_output("set_wins", 32'(err_unexpected), 32'h1);
        cyc();
        err_clr = 1'b0;
        check_output("set_wins_cleared", 32'(err_unexpected), 32'h0);
        check_output("set_wins_credit", 32'(credits_used), 32'h0);
        rsp_ready = 1'b0;

        // empty-tree result (all ones)
        apply_stimulus(1'b1, 1'b0, 2'd2, 16'h0);
        cyc();
        req_valid = 1'b0;
        check_output("empty_pop_strobe", 32'(pop), 32'h4);
        cyc();
        is_level0_pop[2] = 1'b1; pop_tree_id[2] = 2'd2; pop_data[2] = 16'hFFFF;
        cyc();
        is_level0_pop = '0;
        check_output("empty_flag", 32'(rsp_empty), 32'h1);
        check_output("empty_data", 32'(rsp_data), 32'hFFFF);
        check_output("empty_no_err", 32'(err_unexpected), 32'h0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check_output("empty_flag_off", 32'(rsp_empty), 32'h0);
        check_output("empty_credits", 32'(credits_used), 32'h0);

        // reset with a pop in flight: the late result is unexpected
        apply_stimulus(1'b1, 1'b0, 2'd0, 16'h0);
        cyc();
        req_valid = 1'b0;
        check_output("midrst_credit", 32'(credits_used), 32'h1);
        arst_n = 1'b0;
        #1;
        check_output("midrst_cleared", 32'(credits_used), 32'h0);
        check_output("midrst_pop_off", 32'(pop), 32'h0);
        cyc();
        arst_n = 1'b1;
        cyc();
        is_level0_pop[0] = 1'b1; pop_tree_id[0] = 2'd0; pop_data[0] = 16'h0BAD;
        cyc();
        is_level0_pop = '0;
        check_output("midrst_late_err", 32'(err_unexpected), 32'h1);
        check_output("midrst_late_credit", 32'(credits_used), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pifo_req_client.md
Name: pifo_req_client

Overview:
- Requester-side front end for the multi-lane SRAM PIFO tree.
- Accepts one push/pop request per cycle from a valid/ready client and issues it on the tree's lane (tree_id % LEVEL) as the tree's i_push/i_pop/i_tree_id/i_push_data inputs, honouring per-lane task-FIFO full.
- Collects level-0 pop results from all LEVEL lanes into per-lane return FIFOs and drains them round-robin to a valid/ready response port.
- Pop credits guarantee no result is ever dropped.

Parameters:
PTW, 16, payload width
MTW, 0, metadata width; DW = PTW+MTW
LEVEL, 4, number of lanes (RPUs); power of two
TREE_NUM, 4, number of virtual trees; TNB = $clog2(TREE_NUM)
RSP_DEPTH, 8, pop credit pool and per-lane return FIFO depth; power of two

Ports:
i_clk  in  1  clock
i_arst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_op  in  1  1=push, 0=pop
i_req_tree_id  in  TNB  target tree
i_req_data  in  DW  push payload; ignored for pop
o_push  out  LEVEL  per-lane push strobe to tree
o_pop  out  LEVEL  per-lane pop strobe to tree
o_tree_id  out  TNB x LEVEL  per-lane tree id
o_push_data  out  DW x LEVEL  per-lane push payload
i_task_fifo_full  in  LEVEL  per-lane task FIFO full
i_is_level0_pop  in  LEVEL  per-lane pop result valid
i_pop_tree_id  in  TNB x LEVEL  per-lane result tree id
i_pop_data  in  DW x LEVEL  per-lane result data
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed when valid&ready
o_rsp_tree_id  out  TNB  response tree id
o_rsp_data  out  DW  response data
o_rsp_empty  out  1  response data is all ones (tree was empty)
o_credits_used  out  $clog2(RSP_DEPTH+1)  outstanding pops + held results
o_err_unexpected  out  1  sticky: result arrived with no outstanding pop
i_err_clr  in  1  clears o_err_unexpected

Behaviour:
- Reset: all outputs 0. Return FIFOs empty, credit counter 0, RR pointer 0, error flag 0.
- Lane: lane = i_req_tree_id % LEVEL.
- Ready: o_req_ready = !i_task_fifo_full[lane] && !(issue register active on that lane). Pops additionally require credits_used < RSP_DEPTH.
- Ready is combinational from the request inputs; a push may be accepted while credits are exhausted.
- Issue latency: request accepted in cycle N drives o_push[lane] or o_pop[lane] high for exactly cycle N+1, with registered o_tree_id[lane] and o_push_data[lane]. Pops drive data 0.
  - Never push and pop the same lane in the same cycle.
  - Never issue to a lane two cycles back-to-back, because the full signal lags by one cycle.
  - Other lanes' outputs are 0.
- Result capture: every lane k with i_is_level0_pop[k]=1 writes {i_pop_tree_id[k], i_pop_data[k]} into return FIFO k the same cycle. Up to LEVEL writes per cycle.
- Credits:
  - credits_used increments by 1 when a pop is accepted.
  - A captured result moves its credit from outstanding to held.
  - credits_used decrements by 1 when a response is consumed.
  - Net update per cycle: +pop_accept − rsp_consume.
  - Separately track outstanding = pops issued − results returned. A result captured while outstanding==0 sets o_err_unexpected and adds 1 held credit. Saturation at RSP_DEPTH blocks further pops.
  - A result arriving when its FIFO is full is dropped and sets the error flag; this is unreachable under legal traffic.
- Response drain:
  - The round-robin arbiter starting at the RR pointer selects the first non-empty return FIFO.
  - o_rsp_* is driven from a registered output stage (first-word-fall-through). When the stage is empty or consumed this cycle, it is refilled next cycle.
  - After a grant, the RR pointer advances to granted lane+1 mod LEVEL.
  - Order is FIFO within a lane; order across lanes is RR only.
- o_rsp_empty = (o_rsp_data == all ones) && o_rsp_valid.
- Error flag: i_err_clr clears o_err_unexpected. If a set condition occurs in the same cycle, set wins.
- Reset mid-operation: everything clears immediately, and in-flight pops are forgotten. Results returning after reset count as unexpected.

Test Plan:
- Reset, then push tree 2 data 0x1234 at cycle 5 -> o_push=4'b0100, o_tree_id[2]=2, o_push_data[2]=0x1234 at cycle 6 only; no response.
- Pop tree 1 with credits_used=0 -> o_pop=4'b0010 next cycle, credits_used=1. Drive i_is_level0_pop[1] with data 0x00AA 3 cycles later -> o_rsp_valid, tree 1, data 0x00AA next cycle; credits_used=0 after handshake.
- Issue 8 pops with i_rsp_ready=0 and results returned -> 9th pop sees o_req_ready=0 while a push to another lane is still accepted; raising i_rsp_ready frees one credit per response.
- Results on lanes 0 and 3 in the same cycle, RR pointer 0 -> responses ordered lane 0 then lane 3 on consecutive cycles.
- i_task_fifo_full[1]=1 -> requests to trees 1 and 5 stall (o_req_ready=0); deassert -> accepted next cycle. Two back-to-back requests to lane 0 -> second accepted one cycle later.
- Result on lane 2 with no pop outstanding -> o_err_unexpected=1; i_err_clr -> 0. Pop returning data 0xFFFF -> o_rsp_empty=1.
